// File: rtl/decoded_frame_buffer.sv
// Double-buffered store for SC-decoder hard decisions: P bits per write are
// assembled into N-bit frames in ping-pong banks and drained as W-bit words.
module decoded_frame_buffer #(
   parameter int n = 3,
   parameter int P = 1,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         wr_valid,
   input  logic [P-1:0] wr_bits,
   input  logic [n-1:0] wr_index,
   input  logic         wr_last,
   output logic         wr_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         err_overflow
);

   localparam int N   = 1 << n;
   localparam int NW  = N / W;
   localparam int RKW = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [RKW-1:0] RK_LAST = RKW'(NW - 1);
   localparam logic [n-1:0]   IDX_LOW = n'(P - 1);

   typedef enum logic {
      FREE = 1'b0,
      FULL = 1'b1
   } bank_state_t;

   logic [N-1:0]   bank_q  [2];
   logic [N-1:0]   bank_d  [2];
   bank_state_t    state_q [2];
   bank_state_t    state_d [2];
   logic           wp_q, wp_d;
   logic           rp_q, rp_d;
   logic [RKW-1:0] rk_q, rk_d;
   logic           err_q, err_d;

   logic [n-1:0]   wr_base;
   logic [N-1:0]   wr_mask;
   logic [N-1:0]   wr_data;
   logic [N-1:0]   rd_frame;

   // State register.
   // NOTE: the banks are reset like any other register, because unwritten
   // frame bits must read back as 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]  <= '0;
         bank_q[1]  <= '0;
         state_q[0] <= FREE;
         state_q[1] <= FREE;
         wp_q       <= 1'b0;
         rp_q       <= 1'b0;
         rk_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         bank_q  <= bank_d;
         state_q <= state_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         rk_q    <= rk_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic. The write bank is always FREE and the read bank FULL,
   // so a write and a release never target the same bank in one cycle.
   always_comb begin
      // NOTE: every target gets a default first, so no latch can be inferred.
      bank_d  = bank_q;
      state_d = state_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      rk_d    = rk_q;
      err_d   = err_q;

      wr_base = wr_index & ~IDX_LOW;
      wr_mask = '0;
      wr_mask[P-1:0] = '1;
      wr_mask = wr_mask << wr_base;
      wr_data = '0;
      wr_data[P-1:0] = wr_bits;
      wr_data = wr_data << wr_base;

      if (clear) begin
         bank_d[0]  = '0;
         bank_d[1]  = '0;
         state_d[0] = FREE;
         state_d[1] = FREE;
         wp_d       = 1'b0;
         rp_d       = 1'b0;
         rk_d       = '0;
         err_d      = 1'b0;
      end else begin
         if (wr_valid && wr_ready) begin
            bank_d[wp_q] = (bank_q[wp_q] & ~wr_mask) | (wr_data & wr_mask);
            if (wr_last) begin
               state_d[wp_q] = FULL;
               wp_d          = ~wp_q;
            end
         end else if (wr_valid) begin
            err_d = 1'b1;
         end

         // Releasing a bank zeroes it so the next frame starts all-frozen.
         if (out_valid && out_ready) begin
            if (rk_q == RK_LAST) begin
               rk_d          = '0;
               bank_d[rp_q]  = '0;
               state_d[rp_q] = FREE;
               rp_d          = ~rp_q;
            end else begin
               rk_d = rk_q + 1'b1;
            end
         end
      end
   end

   // Outputs depend on registered state only.
   always_comb begin
      wr_ready  = (state_q[wp_q] == FREE);
      out_valid = (state_q[rp_q] == FULL);
      rd_frame  = bank_q[rp_q];
      out_data  = '0;
      if (out_valid) begin
         out_data = rd_frame[rk_q * W +: W];
      end
      out_last  = out_valid && (rk_q == RK_LAST);
   end

   assign err_overflow = err_q;

endmodule

// File: tb/tb_decoded_frame_buffer.sv
// Self-checking bench for decoded_frame_buffer: directed scenarios plus
// random traffic compared against a frame-queue reference model.
module tb_decoded_frame_buffer;

   localparam int n  = 3;
   localparam int P  = 2;
   localparam int W  = 4;
   localparam int N  = 1 << n;
   localparam int NW = N / W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clear = 1'b0;
   logic         wr_valid = 1'b0;
   logic [P-1:0] wr_bits = '0;
   logic [n-1:0] wr_index = '0;
   logic         wr_last = 1'b0;
   logic         out_ready = 1'b0;
   logic         wr_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         err_overflow;

   decoded_frame_buffer #(.n(n), .P(P), .W(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .wr_valid     (wr_valid),
      .wr_bits      (wr_bits),
      .wr_index     (wr_index),
      .wr_last      (wr_last),
      .wr_ready     (wr_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a frame being filled plus a FIFO of committed frames.
   logic [N-1:0] m_fill;
   logic [N-1:0] m_q [$];
   int           m_k;
   bit           m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fill = '0;
      m_q.delete();
      m_k   = 0;
      m_err = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [P-1:0] b, input logic [n-1:0] idx,
                             input logic l, input logic ordy, input logic clr);
      bit rdy;
      bit hs;
      int base;
      if (clr) begin
         model_reset();
         return;
      end
      rdy = (m_q.size() < 2);
      hs  = (m_q.size() > 0) && ordy;
      if (hs) begin
         m_k++;
         if (m_k == NW) begin
            m_k = 0;
            void'(m_q.pop_front());
         end
      end
      if (v && rdy) begin
         base = int'(idx) - (int'(idx) % P);
         for (int j = 0; j < P; j++) m_fill[base + j] = b[j];
         if (l) begin
            m_q.push_back(m_fill);
            m_fill = '0;
         end
      end else if (v) begin
         m_err = 1'b1;
      end
   endtask

   task automatic check_model();
      logic [N-1:0] f;
      logic [W-1:0] ed;
      bit           ev;
      ev = (m_q.size() > 0);
      ed = '0;
      if (ev) begin
         f  = m_q[0];
         ed = f[m_k * W +: W];
      end
      check("wr_ready", wr_ready, (m_q.size() < 2));
      check("out_valid", out_valid, ev);
      check("out_data", out_data, ed);
      check("out_last", out_last, ev && (m_k == NW - 1));
      check("err_overflow", err_overflow, m_err);
   endtask

   // Called at a falling edge: drive, advance the model, sample at the next falling edge.
   task automatic tick(input logic v, input logic [P-1:0] b, input logic [n-1:0] idx,
                       input logic l, input logic ordy, input logic clr);
      wr_valid  = v;
      wr_bits   = b;
      wr_index  = idx;
      wr_last   = l;
      out_ready = ordy;
      clear     = clr;
      model_step(v, b, idx, l, ordy, clr);
      @(negedge clk);
      check_model();
   endtask

   task automatic idle(input logic ordy);
      tick(1'b0, '0, '0, 1'b0, ordy, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst out_valid", out_valid, 1'b0);
      check("rst wr_ready", wr_ready, 1'b1);
      check("rst out_data", out_data, 4'h0);
      check("rst err", err_overflow, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_model();

      // Basic frame: words 1001 then 0011.
      tick(1'b1, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 2'b10, 3'd2, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 2'b11, 3'd4, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 2'b00, 3'd6, 1'b1, 1'b0, 1'b0);
      check("t1 valid", out_valid, 1'b1);
      check("t1 w0", out_data, 4'b1001);
      check("t1 last0", out_last, 1'b0);
      idle(1'b1);
      check("t1 w1", out_data, 4'b0011);
      check("t1 last1", out_last, 1'b1);
      idle(1'b1);
      check("t1 drained", out_valid, 1'b0);

      // Sparse frame: only index 6 written (index 7 ignored low bit).
      tick(1'b1, 2'b11, 3'd7, 1'b1, 1'b0, 1'b0);
      check("sparse w0", out_data, 4'b0000);
      idle(1'b1);
      check("sparse w1", out_data, 4'b1100);
      idle(1'b1);

      // Backpressure: first frame held while a second one fills and commits.
      tick(1'b1, 2'b11, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 2'b00, 3'd4, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 2'b10, 3'd6, 1'b1, 1'b0, 1'b0);
      check("bp w0", out_data, 4'h7);
      tick(1'b1, 2'b10, 3'd0, 1'b0, 1'b0, 1'b0);
      check("bp hold1", out_data, 4'h7);
      tick(1'b1, 2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
      check("bp hold2", out_data, 4'h7);
      tick(1'b1, 2'b11, 3'd4, 1'b0, 1'b0, 1'b0);
      check("bp hold3", out_data, 4'h7);
      tick(1'b1, 2'b01, 3'd6, 1'b1, 1'b0, 1'b0);
      check("bp hold4", out_data, 4'h7);
      check("bp full", wr_ready, 1'b0);
      idle(1'b0);
      check("bp hold5", out_valid, 1'b1);
      tick(1'b1, 2'b11, 3'd0, 1'b1, 1'b0, 1'b0);
      check("bp overflow", err_overflow, 1'b1);
      check("bp hold6", out_data, 4'h7);
      repeat (4) idle(1'b1);
      check("bp drained", out_valid, 1'b0);

      // Reset mid-drain, after word 0 has gone.
      tick(1'b1, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 2'b11, 3'd4, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      check("rd before", out_data, 4'b0011);
      #2 rst_n = 1'b0;
      #1;
      check("rd valid", out_valid, 1'b0);
      check("rd data", out_data, 4'h0);
      check("rd ready", wr_ready, 1'b1);
      check("rd err", err_overflow, 1'b0);
      model_reset();
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_model();
      tick(1'b1, 2'b11, 3'd2, 1'b1, 1'b0, 1'b0);
      check("rd new w0", out_data, 4'b1100);
      idle(1'b1);
      check("rd new w1", out_data, 4'b0000);
      idle(1'b1);

      // Ping-pong: A5 then 3C back-to-back with out_ready high.
      tick(1'b1, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 2'b01, 3'd2, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 2'b10, 3'd4, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 2'b10, 3'd6, 1'b1, 1'b1, 1'b0);
      check("pp A w0", out_data, 4'h5);
      tick(1'b1, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0);
      check("pp A w1", out_data, 4'hA);
      check("pp A last", out_last, 1'b1);
      tick(1'b1, 2'b11, 3'd2, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 2'b11, 3'd4, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 2'b00, 3'd6, 1'b1, 1'b1, 1'b0);
      check("pp B w0", out_data, 4'hC);
      idle(1'b1);
      check("pp B w1", out_data, 4'h3);
      check("pp B last", out_last, 1'b1);
      idle(1'b1);

      // Clear coinciding with a committing write.
      tick(1'b1, 2'b11, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 2'b10, 3'd6, 1'b1, 1'b0, 1'b1);
      check("clr valid", out_valid, 1'b0);
      check("clr ready", wr_ready, 1'b1);
      check("clr err", err_overflow, 1'b0);
      tick(1'b1, 2'b01, 3'd6, 1'b1, 1'b0, 1'b0);
      check("clr fresh w0", out_data, 4'h0);
      idle(1'b1);
      idle(1'b1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 9) < 7),
              P'($urandom),
              n'($urandom_range(0, N - 1)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 127) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
